// File: rtl/mips_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mips_pkg : shared constants and pipeline-register bundle types        |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package mips_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam logic [INSTR_W-1:0] MIPS_NOP_WORD = 32'h0000_0000;  // sll $0,$0,0
  localparam logic [31:0]        MIPS_RESET_PC = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Shared by IF/ID and ID/EX so the instruction context travels as one unit.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc4;
    logic               valid;
  } if_id_t;

endpackage
`default_nettype wire

// File: rtl/stat_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | stat_counter : wrapping event counter with enable and sync reset      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module stat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + C_ONE;
    end
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | if_stage : MIPS instruction fetch, PC register and IF/ID register     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = MIPS_RESET_PC,
  parameter int unsigned IMEM_BYTES = 1024,
  parameter int unsigned COUNT_W    = 16,
  parameter logic [31:0] NOP_WORD   = MIPS_NOP_WORD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic [31:0]        imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        pc_out,
  output logic [31:0]        if_id_instr,
  output logic [31:0]        if_id_pc4,
  output logic               if_id_valid,
  output logic [COUNT_W-1:0] fetch_count,
  output logic [COUNT_W-1:0] stall_count,
  output logic [COUNT_W-1:0] flush_count,
  output logic               misalign_err,
  output logic               range_err
);

  localparam logic [32:0] C_IMEM_LIMIT = 33'(IMEM_BYTES);

  logic [31:0] pc_q, pc_d;
  if_id_t      if_id_q, if_id_d;
  logic        misalign_q, misalign_d;
  logic        range_q, range_d;

  logic [31:0] w_pc_plus4;
  logic        w_in_range;
  logic        w_fetch_en;
  logic        w_stall_en;
  logic        w_flush_en;

  assign w_pc_plus4 = pc_q + 32'd4;
  assign w_in_range = ({1'b0, pc_q} < C_IMEM_LIMIT);

  // Priority: redirect beats stall beats sequential fetch.
  always_comb begin
    pc_d       = pc_q;
    if_id_d    = if_id_q;
    misalign_d = misalign_q;
    range_d    = range_q;
    w_fetch_en = 1'b0;
    w_stall_en = 1'b0;
    w_flush_en = 1'b0;

    if (redirect_valid) begin
      pc_d           = {redirect_pc[31:2], 2'b00};
      if_id_d.instr  = NOP_WORD;
      if_id_d.valid  = 1'b0;
      w_flush_en     = 1'b1;
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
    end else if (stall) begin
      w_stall_en = 1'b1;
    end else begin
      pc_d = w_pc_plus4;
      if (w_in_range) begin
        if_id_d.instr = imem_rdata;
        if_id_d.pc4   = w_pc_plus4;
        if_id_d.valid = 1'b1;
        w_fetch_en    = 1'b1;
      end else begin
        if_id_d.instr = NOP_WORD;
        if_id_d.valid = 1'b0;
        range_d       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      if_id_q.instr <= NOP_WORD;
      if_id_q.pc4   <= 32'h0000_0000;
      if_id_q.valid <= 1'b0;
      misalign_q    <= 1'b0;
      range_q       <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      if_id_q    <= if_id_d;
      misalign_q <= misalign_d;
      range_q    <= range_d;
    end
  end

  stat_counter #(.WIDTH(COUNT_W)) u_fetch_cnt (
    .clk     (clk),
    .rst     (reset),
    .en_i    (w_fetch_en),
    .count_o (fetch_count)
  );

  stat_counter #(.WIDTH(COUNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst     (reset),
    .en_i    (w_stall_en),
    .count_o (stall_count)
  );

  stat_counter #(.WIDTH(COUNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst     (reset),
    .en_i    (w_flush_en),
    .count_o (flush_count)
  );

  assign imem_addr    = pc_q;
  assign pc_out       = pc_q;
  assign if_id_instr  = if_id_q.instr;
  assign if_id_pc4    = if_id_q.pc4;
  assign if_id_valid  = if_id_q.valid;
  assign misalign_err = misalign_q;
  assign range_err    = range_q;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_if_stage : directed vector bench for if_stage                      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_if_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters.
  logic        a_reset, a_stall, a_rv;
  logic [31:0] a_rpc, a_addr, a_rdata, a_pc, a_instr, a_pc4;
  logic        a_valid, a_mis, a_rng;
  logic [15:0] a_fc, a_sc, a_flc;
  assign a_rdata = 32'h1000_0000 | a_addr;

  if_stage u_dut_a (
    .clk(clk), .reset(a_reset), .stall(a_stall),
    .redirect_valid(a_rv), .redirect_pc(a_rpc),
    .imem_addr(a_addr), .imem_rdata(a_rdata), .pc_out(a_pc),
    .if_id_instr(a_instr), .if_id_pc4(a_pc4), .if_id_valid(a_valid),
    .fetch_count(a_fc), .stall_count(a_sc), .flush_count(a_flc),
    .misalign_err(a_mis), .range_err(a_rng)
  );

  // Instance B: tiny memory and narrow counters for boundary cases.
  logic        b_reset, b_stall, b_rv;
  logic [31:0] b_rpc, b_addr, b_rdata, b_pc, b_instr, b_pc4;
  logic        b_valid, b_mis, b_rng;
  logic [3:0]  b_fc, b_sc, b_flc;
  assign b_rdata = 32'h1000_0000 | b_addr;

  if_stage #(.IMEM_BYTES(16), .COUNT_W(4)) u_dut_b (
    .clk(clk), .reset(b_reset), .stall(b_stall),
    .redirect_valid(b_rv), .redirect_pc(b_rpc),
    .imem_addr(b_addr), .imem_rdata(b_rdata), .pc_out(b_pc),
    .if_id_instr(b_instr), .if_id_pc4(b_pc4), .if_id_valid(b_valid),
    .fetch_count(b_fc), .stall_count(b_sc), .flush_count(b_flc),
    .misalign_err(b_mis), .range_err(b_rng)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        stl;
    logic        rv;
    logic [31:0] rpc;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    int          fc;
    int          sc;
    int          flc;
    logic        mis;
  } vec_t;

  vec_t vecs[16];

  task automatic step_b(input logic r, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    b_reset = r; b_stall = 1'b0; b_rv = rv; b_rpc = rpc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_reset = 1'b1; a_stall = 1'b0; a_rv = 1'b0; a_rpc = '0;
    b_reset = 1'b1; b_stall = 1'b0; b_rv = 1'b0; b_rpc = '0;

    //          rst   stl   rv    rpc          pc           instr        pc4          v   fc sc flc mis
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,      32'h00,      32'h0,       32'h00,      1'b0, 0, 0, 0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,      32'h00,      32'h0,       32'h00,      1'b0, 0, 0, 0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,      32'h04,      32'h10000000,32'h04,      1'b1, 1, 0, 0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,      32'h08,      32'h10000004,32'h08,      1'b1, 2, 0, 0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,      32'h0C,      32'h10000008,32'h0C,      1'b1, 3, 0, 0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,      32'h10,      32'h1000000C,32'h10,      1'b1, 4, 0, 0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,      32'h10,      32'h1000000C,32'h10,      1'b1, 4, 1, 0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,      32'h10,      32'h1000000C,32'h10,      1'b1, 4, 2, 0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,      32'h14,      32'h10000010,32'h14,      1'b1, 5, 2, 0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 32'h40,     32'h40,      32'h0,       32'h14,      1'b0, 5, 2, 1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,      32'h44,      32'h10000040,32'h44,      1'b1, 6, 2, 1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 32'h2E,     32'h2C,      32'h0,       32'h44,      1'b0, 6, 2, 2, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,      32'h30,      32'h1000002C,32'h30,      1'b1, 7, 2, 2, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 32'h0,      32'h30,      32'h1000002C,32'h30,      1'b1, 7, 3, 2, 1'b1};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 32'h0,      32'h00,      32'h0,       32'h00,      1'b0, 0, 0, 0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 32'h0,      32'h04,      32'h10000000,32'h04,      1'b1, 1, 0, 0, 1'b0};

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      a_reset = vecs[i].rst; a_stall = vecs[i].stl; a_rv = vecs[i].rv; a_rpc = vecs[i].rpc;
      @(posedge clk);
      #1;
      chk("pc",    i, a_pc, vecs[i].pc);
      chk("addr",  i, a_addr, vecs[i].pc);
      chk("instr", i, a_instr, vecs[i].instr);
      chk("pc4",   i, a_pc4, vecs[i].pc4);
      chk("valid", i, {31'b0, a_valid}, {31'b0, vecs[i].valid});
      chk("fetch", i, {16'b0, a_fc}, 32'(vecs[i].fc));
      chk("stall", i, {16'b0, a_sc}, 32'(vecs[i].sc));
      chk("flush", i, {16'b0, a_flc}, 32'(vecs[i].flc));
      chk("mis",   i, {31'b0, a_mis}, {31'b0, vecs[i].mis});
      chk("rng",   i, {31'b0, a_rng}, 32'h0);
    end

    // Out-of-range fetch on the 16-byte memory.
    step_b(1'b1, 1'b0, '0);
    step_b(1'b1, 1'b0, '0);
    chk("b_rst_pc",  0, b_pc, 32'h0);
    chk("b_rst_rng", 0, {31'b0, b_rng}, 32'h0);
    for (int k = 0; k < 4; k++) step_b(1'b0, 1'b0, '0);
    chk("b_pc",    4, b_pc, 32'h10);
    chk("b_instr", 4, b_instr, 32'h1000000C);
    chk("b_fetch", 4, {28'b0, b_fc}, 32'd4);
    chk("b_rng",   4, {31'b0, b_rng}, 32'h0);
    step_b(1'b0, 1'b0, '0);
    chk("b_pc",    5, b_pc, 32'h14);
    chk("b_rng",   5, {31'b0, b_rng}, 32'h1);
    chk("b_valid", 5, {31'b0, b_valid}, 32'h0);
    chk("b_instr", 5, b_instr, 32'h0);
    chk("b_fetch", 5, {28'b0, b_fc}, 32'd4);
    step_b(1'b0, 1'b0, '0);
    chk("b_rng_sticky", 6, {31'b0, b_rng}, 32'h1);
    chk("b_pc",         6, b_pc, 32'h18);

    // Counter wrap: 17 in-range fetches, looping back with redirects.
    step_b(1'b1, 1'b0, '0);
    chk("b_rst_rng", 1, {31'b0, b_rng}, 32'h0);
    chk("b_rst_fc",  1, {28'b0, b_fc}, 32'h0);
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) step_b(1'b0, 1'b0, '0);
      chk("b_wrap_fc", r, {28'b0, b_fc}, 32'((4 * (r + 1)) % 16));
      step_b(1'b0, 1'b1, 32'h0);
    end
    step_b(1'b0, 1'b0, '0);
    chk("b_wrap_fc1", 0, {28'b0, b_fc}, 32'd1);
    chk("b_wrap_flc", 0, {28'b0, b_flc}, 32'd4);
    chk("b_wrap_pc",  0, b_pc, 32'h4);
    chk("b_wrap_rng", 0, {31'b0, b_rng}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
